// File: rtl/mem_stage.sv
// LC-3b memory stage: data-cache sequencer for LDB/STB/LDR/STR/LDI/STI; non-memory ops pass alu_in straight through.
// Latency: 3 cycles minimum for direct ops (present, ACCESS, DONE); LDI/STI 4; each cache wait cycle adds one.
// Backpressure: mem_stall freezes upstream while a request is open; build option MEM_STALL_COUNT_EN enables stall_count.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic [15:0] alu_in,
  input  logic [15:0] store_in,
  output logic [15:0] dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_wmask,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] mem_data_out,
  output logic        mem_stall,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, INDIRECT, DONE} state_t;

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [15:0] addr_q;
  logic [15:0] store_q;
  logic [14:0] ptr_q;
  logic [15:0] load_q;

  logic start;
  logic op_is_byte, op_is_load, op_is_ind;
  logic [15:0] word_addr;

  assign start      = valid_in && (opcode == OP_LDB || opcode == OP_STB || opcode == OP_LDR ||
                                   opcode == OP_STR || opcode == OP_LDI || opcode == OP_STI);
  assign op_is_byte = (op_q == OP_LDB) || (op_q == OP_STB);
  assign op_is_load = (op_q == OP_LDB) || (op_q == OP_LDR) || (op_q == OP_LDI);
  assign op_is_ind  = (op_q == OP_LDI) || (op_q == OP_STI);
  assign word_addr  = {addr_q[15:1], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = ACCESS;
      ACCESS:   if (dmem_resp) state_d = op_is_ind ? INDIRECT : DONE;
      INDIRECT: if (dmem_resp) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 4'h0;
      addr_q  <= 16'h0;
      store_q <= 16'h0;
      ptr_q   <= 15'h0;
      load_q  <= 16'h0;
    end else begin
      if (state_q == IDLE && start) begin
        op_q    <= opcode;
        addr_q  <= alu_in;
        store_q <= store_in;
      end
      if (state_q == ACCESS && dmem_resp) begin
        if (op_is_ind) ptr_q <= dmem_rdata[15:1];
        else if (op_q == OP_LDR) load_q <= dmem_rdata;
        else if (op_q == OP_LDB) load_q <= {8'h00, addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
      end
      if (state_q == INDIRECT && dmem_resp && op_q == OP_LDI) load_q <= dmem_rdata;
    end
  end

  // Request outputs are pure functions of state so reset drops them without waiting for a clock.
  always_comb begin
    dmem_addr    = 16'h0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = 2'b00;
    dmem_wdata   = 16'h0;
    mem_data_out = 16'h0;
    mem_stall    = 1'b0;
    case (state_q)
      IDLE: begin
        mem_data_out = alu_in;
        mem_stall    = start;
      end
      ACCESS: begin
        mem_stall = 1'b1;
        dmem_addr = op_is_byte ? addr_q : word_addr;
        if (op_q == OP_STB) begin
          dmem_write = 1'b1;
          dmem_wmask = addr_q[0] ? 2'b10 : 2'b01;
          dmem_wdata = {store_q[7:0], store_q[7:0]};
        end else if (op_q == OP_STR) begin
          dmem_write = 1'b1;
          dmem_wmask = 2'b11;
          dmem_wdata = store_q;
        end else begin
          dmem_read = 1'b1;
        end
      end
      INDIRECT: begin
        mem_stall = 1'b1;
        dmem_addr = {ptr_q, 1'b0};
        if (op_q == OP_STI) begin
          dmem_write = 1'b1;
          dmem_wmask = 2'b11;
          dmem_wdata = store_q;
        end else begin
          dmem_read = 1'b1;
        end
      end
      DONE: mem_data_out = op_is_load ? load_q : addr_q;
      default: ;
    endcase
  end

`ifdef MEM_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt_q <= 16'h0;
    else if (mem_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'h1;
  end
  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table of memory/non-memory ops with a cache responder, plus a mid-access reset sequence.
module tb_mem_stage;

  logic        clk, rst_n, valid_in, dmem_read, dmem_write, dmem_resp, mem_stall;
  logic [3:0]  opcode;
  logic [15:0] alu_in, store_in, dmem_addr, dmem_wdata, dmem_rdata, mem_data_out, stall_count;
  logic [1:0]  dmem_wmask;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .alu_in(alu_in),
    .store_in(store_in), .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] alu, st, rd1, rd2;
    int          wt;
    logic [15:0] a1; logic r1, w1; logic [1:0] m1; logic [15:0] d1;
    logic [15:0] a2; logic r2, w2; logic [1:0] m2; logic [15:0] d2;
    logic [15:0] out;
    int          stall, nresp;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] sb_q[$];
  int total = 0, passed = 0;
  int exp_sc = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nresp, waitc, stalls;
    bit done;
    logic [15:0] exp_out;
    valid_in = 1'b1; opcode = v.op; alu_in = v.alu; store_in = v.st; dmem_resp = 1'b0;
    sb_q.push_back(v.out);
    nresp = 0; waitc = 0; stalls = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (mem_stall) stalls++;
      if (dmem_read || dmem_write) begin
        if (nresp == 0) begin
          chk($sformatf("v%0d addr1", idx), dmem_addr, v.a1);
          chk($sformatf("v%0d read1", idx), {15'h0, dmem_read}, {15'h0, v.r1});
          chk($sformatf("v%0d write1", idx), {15'h0, dmem_write}, {15'h0, v.w1});
          chk($sformatf("v%0d wmask1", idx), {14'h0, dmem_wmask}, {14'h0, v.m1});
          chk($sformatf("v%0d wdata1", idx), dmem_wdata, v.d1);
        end else begin
          chk($sformatf("v%0d addr2", idx), dmem_addr, v.a2);
          chk($sformatf("v%0d read2", idx), {15'h0, dmem_read}, {15'h0, v.r2});
          chk($sformatf("v%0d write2", idx), {15'h0, dmem_write}, {15'h0, v.w2});
          chk($sformatf("v%0d wmask2", idx), {14'h0, dmem_wmask}, {14'h0, v.m2});
          chk($sformatf("v%0d wdata2", idx), dmem_wdata, v.d2);
        end
        if (nresp == 0 && waitc < v.wt) waitc++;
        else begin
          dmem_resp = 1'b1;
          dmem_rdata = (nresp == 0) ? v.rd1 : v.rd2;
          nresp++;
        end
      end else if (!mem_stall) begin
        exp_out = sb_q.pop_front();
        chk($sformatf("v%0d data_out", idx), mem_data_out, exp_out);
        chk($sformatf("v%0d resp_count", idx), 16'(nresp), 16'(v.nresp));
        done = 1;
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end
    if (!done) begin
      exp_out = sb_q.pop_front();
      total++;
      $display("FAIL v%0d timeout: got no completion, expected %h", idx, exp_out);
    end
    chk($sformatf("v%0d stall_cycles", idx), 16'(stalls), 16'(v.stall));
`ifdef MEM_STALL_COUNT_EN
    exp_sc += v.stall;
`endif
    chk($sformatf("v%0d stall_count", idx), stall_count, 16'(exp_sc));
    valid_in = 1'b0;
  endtask

  initial begin
    //            op     alu      st       rd1      rd2      wt a1       r w m      d1       a2       r w m      d2       out      stall nresp
    vecs[0] = '{4'b0110, 16'h3001, 16'h0000, 16'hBEEF, 16'h0000, 2, 16'h3000, 1, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'hBEEF, 4, 1};
    vecs[1] = '{4'b0010, 16'h4005, 16'h0000, 16'hA55A, 16'h0000, 0, 16'h4005, 1, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h00A5, 2, 1};
    vecs[2] = '{4'b0010, 16'h4004, 16'h0000, 16'hA55A, 16'h0000, 0, 16'h4004, 1, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h005A, 2, 1};
    vecs[3] = '{4'b0011, 16'h2003, 16'h1234, 16'h0000, 16'h0000, 1, 16'h2003, 0, 1, 2'b10, 16'h3434, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h2003, 3, 1};
    vecs[4] = '{4'b0011, 16'h2002, 16'h12AB, 16'h0000, 16'h0000, 0, 16'h2002, 0, 1, 2'b01, 16'hABAB, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h2002, 2, 1};
    vecs[5] = '{4'b0111, 16'h5557, 16'hCAFE, 16'h0000, 16'h0000, 0, 16'h5556, 0, 1, 2'b11, 16'hCAFE, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h5557, 2, 1};
    vecs[6] = '{4'b1010, 16'h1000, 16'h0000, 16'h2002, 16'h7777, 0, 16'h1000, 1, 0, 2'b00, 16'h0000, 16'h2002, 1, 0, 2'b00, 16'h0000, 16'h7777, 3, 2};
    vecs[7] = '{4'b1011, 16'h1001, 16'h9999, 16'h3003, 16'h0000, 1, 16'h1000, 1, 0, 2'b00, 16'h0000, 16'h3002, 0, 1, 2'b11, 16'h9999, 16'h1001, 4, 2};
    vecs[8] = '{4'b0001, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0042, 0, 0};
    vecs[9] = '{4'b0110, 16'h0010, 16'h0000, 16'h1234, 16'h0000, 0, 16'h0010, 1, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h1234, 2, 1};

    rst_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; alu_in = 16'h0; store_in = 16'h0;
    dmem_rdata = 16'h0; dmem_resp = 1'b0;
    #3;
    chk("rst addr", dmem_addr, 16'h0);
    chk("rst rw", {14'h0, dmem_read, dmem_write}, 16'h0);
    chk("rst wmask", {14'h0, dmem_wmask}, 16'h0);
    chk("rst wdata", dmem_wdata, 16'h0);
    chk("rst stall", {15'h0, mem_stall}, 16'h0);
    chk("rst stall_count", stall_count, 16'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while an STR is in ACCESS, followed by a stale response in IDLE.
    valid_in = 1'b1; opcode = 4'b0111; alu_in = 16'h6000; store_in = 16'h1111;
    @(posedge clk); #1;
    chk("str access write", {15'h0, dmem_write}, 16'h1);
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    chk("mid rst write", {15'h0, dmem_write}, 16'h0);
    chk("mid rst addr", dmem_addr, 16'h0);
    chk("mid rst stall", {15'h0, mem_stall}, 16'h0);
    chk("mid rst stall_count", stall_count, 16'h0);
    exp_sc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; alu_in = 16'h5555; dmem_rdata = 16'hFFFF; dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("stale c%0d data_out", c), mem_data_out, 16'h5555);
      chk($sformatf("stale c%0d rw", c), {14'h0, dmem_read, dmem_write}, 16'h0);
      chk($sformatf("stale c%0d stall", c), {15'h0, mem_stall}, 16'h0);
      chk($sformatf("stale c%0d stall_count", c), stall_count, 16'h0);
      @(posedge clk); #1;
    end
    run_vec(10, vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
